// File: rtl/aes_128_pkg.sv
// Shared constants and helpers for the AES-128 round datapath.
// Byte i of the state lives at [8i+7:8i]; column c holds bytes 4c..4c+3.
package aes_128_pkg;

  localparam int unsigned NBYTES = 16;
  localparam int unsigned NCOLS  = 4;
  localparam int unsigned NROWS  = 4;
  localparam int unsigned COL_W  = 32;

  localparam logic [7:0] POLY    = 8'h1B;
  localparam logic [3:0] NROUNDS = 4'd10;

  function automatic int unsigned byte_lsb(
    input int unsigned c,
    input int unsigned r
  );
    return 8 * (NROWS * c + r);
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] a
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[7:0];
    a1 = a[15:8];
    a2 = a[23:16];
    a3 = a[31:24];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/aes_128_mixcolumn.sv
// One MixColumns column: 32-bit column in, 32-bit column out.
// Purely combinational.
module aes_128_mixcolumn
  import aes_128_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  assign col_o = mix_col(col_i);

endmodule

// File: rtl/aes_128_mixcol_addkey.sv
// AES-128 MixColumns + AddRoundKey stage with valid/last alignment.
// AES_128_ROUND_CHECK_EN adds a round counter driving a sticky err.
module aes_128_mixcol_addkey
  import aes_128_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  input  logic         in_valid,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [127:0] sb_data,
  input  logic [127:0] round_key,
  output logic [127:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  output logic         err
);

  logic [SBOX_LAT-1:0] v_q, v_d;
  logic [SBOX_LAT-1:0] f_q, f_d;
  logic [SBOX_LAT-1:0] l_q, l_d;
  logic v_al, f_al, l_al;
  logic take;

  logic [127:0] mixed, mc, res;
  logic [127:0] data_q;
  logic valid_q, last_q;

  assign v_al = v_q[SBOX_LAT-1];
  assign f_al = f_q[SBOX_LAT-1];
  assign l_al = l_q[SBOX_LAT-1];
  assign take = v_al & ~kill;

  // Shift the handshake flags one step toward the aligned cycle.
  always_comb begin
    v_d = v_q << 1;
    f_d = f_q << 1;
    l_d = l_q << 1;
    v_d[0] = in_valid;
    f_d[0] = in_first;
    l_d[0] = in_last;
  end

  // Delay pipe state; kill flushes every in-flight token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else if (kill) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else begin
      v_q <= v_d;
      f_q <= f_d;
      l_q <= l_d;
    end
  end

  for (genvar c = 0; c < NCOLS; c++) begin : g_col
    aes_128_mixcolumn u_mc (
      .col_i (sb_data[c*COL_W +: COL_W]),
      .col_o (mixed[c*COL_W +: COL_W])
    );
  end

  // Final round skips the mix; first+last together also bypasses.
  assign mc  = l_al ? sb_data : mixed;
  assign res = mc ^ round_key;

  // Output register; data holds when no token lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= take;
      last_q  <= take & l_al;
      if (take) begin
        data_q <= res;
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifdef AES_128_ROUND_CHECK_EN
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rnd;
  logic err_q, err_d;

  // rnd is the round number of the aligned token; cnt_q==0 means
  // no block is open.
  assign rnd = f_al ? 4'd1 : cnt_q + 4'd1;

  // Round-sequence checker next state.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (take) begin
      unique case (1'b1)
        f_al && l_al: begin
          err_d = 1'b1;
          cnt_d = '0;
        end
        l_al: begin
          if (rnd != NROUNDS) err_d = 1'b1;
          cnt_d = '0;
        end
        default: begin
          if (!f_al && cnt_q == '0) err_d = 1'b1;
          if (rnd == NROUNDS) err_d = 1'b1;
          cnt_d = rnd;
        end
      endcase
    end
  end

  // Counter and sticky error; only reset clears err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_first;
  assign unused_first = f_al;
  assign err = 1'b0;
`endif

endmodule

// File: doc/aes_128_mixcol_addkey.md
Name: aes_128_mixcol_addkey

Overview:
- Round stage directly downstream of aes_128_subbytes. Its sb_data input is the SubBytes/ShiftRows output bus, which that stage returns SBOX_LAT cycles after its address inputs are presented.
- Applies MixColumns, or bypasses it on the final round, then XORs the round key and registers the result. The result feeds back into the round mux or leaves the core as ciphertext.
- Tracks valid/last alongside the S-box BRAM read latency so that the controller sees a single aligned out_valid.

Parameters:
- SBOX_LAT, 1, read latency in cycles of the S-box BRAM in the upstream stage (1..2).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- kill  in  1  synchronous flush, same net that drives the upstream S-box kill.
- in_valid  in  1  high in the cycle a state is presented to the upstream subbytes stage.
- in_first  in  1  qualifies in_valid: this is round 1 of a new block.
- in_last  in  1  qualifies in_valid: this is the final round (no MixColumns).
- sb_data  in  128  upstream subbytes output; byte i is at [8i+7:8i], column c holds bytes 4c..4c+3.
- round_key  in  128  round key, same byte order; sampled in the aligned cycle (in_valid delayed by SBOX_LAT).
- out_data  out  128  registered round result.
- out_valid  out  1  out_data is valid this cycle.
- out_last  out  1  out_data is the final ciphertext.
- err  out  1  sticky round-sequence error; see Optional Feature.

Behaviour:
- Reset (rst_n low, async): out_data=0, out_valid=0, out_last=0, err=0. The valid/first/last delay pipes and the round counter are cleared.
- Delay pipe:
  - in_valid, in_first and in_last each pass through an SBOX_LAT-deep shift register.
  - The pipe output asserted in cycle t+SBOX_LAT is v_al, with f_al/l_al for first/last.
- Datapath in the aligned cycle:
  - Per column, MixColumns: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0).
  - When l_al=1, MixColumns is bypassed (mc=sb_data).
  - res = mc ^ round_key.
- Output register:
  - On v_al=1: out_data<=res, out_valid<=1, out_last<=l_al.
  - Otherwise out_valid<=0 and out_last<=0; out_data holds its value.
- Latency: out_valid rises SBOX_LAT+1 cycles after in_valid, i.e. 2 cycles at default. This completes the 3-cycle round: present, S-box read, mix/key.
- Throughput: fully pipelined. in_valid may be asserted every cycle and each token is independent. There is no backpressure; the consumer must accept out_valid.
- kill:
  - Clears the delay pipes, out_valid and out_last on the next edge; out_data is left unchanged.
  - kill together with in_valid: kill wins, and the token is dropped.
  - kill does not clear err.
- rst_n deasserted mid-operation: all in-flight tokens are lost and no spurious out_valid is produced.
- in_first and in_last both high: treated as last (bypass). This is also flagged as an error when the checker is enabled.

Optional Feature:
- Macro: AES_128_ROUND_CHECK_EN.
- When defined, a 4-bit round counter runs on aligned tokens:
  - f_al sets it to 1.
  - Each other v_al increments it.
  - l_al expects a count of 10 and resets the counter to 0.
- err is set (sticky until rst_n) on any of:
  - l_al with count != 10;
  - a non-first token with count = 0;
  - a non-last token with count = 10;
  - f_al and l_al together.
- When not defined: no counter, err tied to 0.

Decomposition:
- Shared package aes_128_pkg holds the byte-index mapping constants, the reduction polynomial 8'h1B and the round count 10. The package also exports xtime and a column mixing function.
- One sub-module, aes_128_mixcolumn: purely combinational, 32-bit column in and 32-bit out. It is instantiated 4 times.

Test Plan:
- Single round, FIPS-197 App. B round 1: in_valid+in_first, then sb_data=d4bf5d30e0b452aeb84111f11e2798e5 (byte0 first) with round_key=a0fafe1788542cb123a339392a6c7605 → out_valid 2 cycles later, out_data=a49c7ff2689f352b6b5bea43026a5049 (byte0 first), out_last=0.
- Single column db,13,53,45 with key 0 → 8e,4d,a1,bc. Column c6,c6,c6,c6 → c6,c6,c6,c6.
- Last round: in_last=1, sb_data=A5..A5, key=0F..0F → out_data=AA..AA (no mix), out_last=1.
- Back-to-back tokens on 3 consecutive cycles → 3 consecutive out_valid pulses with the correct per-token data; kill asserted on the 2nd aligned cycle → only the 1st pulse appears.
- rst_n pulsed low while 2 tokens are in flight → out_valid stays 0 and out_data reads 0.
- With AES_128_ROUND_CHECK_EN:
  - 10-round sequence first..last → err=0.
  - in_last on round 9 → err=1 and held through a subsequent kill.
